// File: rtl/activation_stream.sv
// rtl/activation_stream.sv - two-stage streaming activation unit; optional per-frame zero stats under ACTIVATION_STREAM_STATS_EN
module activation_stream #(
   parameter int BITWIDTH    = 32,
   parameter int LANES       = 10,
   parameter int FRAME_BEATS = 1
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [1:0]                             mode,
   input  logic [4:0]                             leak_shift,
   input  logic signed [BITWIDTH-1:0]             clamp_max,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic signed [BITWIDTH-1:0]             in_data [LANES],
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic signed [BITWIDTH-1:0]             out_data [LANES],
   output logic                                   out_last,
   output logic [$clog2(LANES*FRAME_BEATS+1)-1:0] zero_count,
   output logic                                   zero_count_valid
);

   // A one-beat frame still needs a 1-bit counter so the compare logic stays uniform.
   localparam int CNT_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
   localparam int ZC_W  = $clog2(LANES*FRAME_BEATS+1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BEATS-1);

   localparam logic [1:0] MODE_IDENTITY = 2'b00;
   localparam logic [1:0] MODE_RELU     = 2'b01;
   localparam logic [1:0] MODE_LEAKY    = 2'b10;
   localparam logic [1:0] MODE_CLAMP    = 2'b11;

   // Frame tracking and the configuration latched at the first beat of a frame.
   logic [CNT_W-1:0]           r_beat_cnt;
   logic [1:0]                 r_cfg_mode;
   logic [4:0]                 r_cfg_shift;
   logic signed [BITWIDTH-1:0] r_cfg_clamp;

   // Stage 1: raw operands plus the per-beat config and last flag.
   logic                       r_s1_valid;
   logic                       r_s1_last;
   logic [1:0]                 r_s1_mode;
   logic [4:0]                 r_s1_shift;
   logic signed [BITWIDTH-1:0] r_s1_clamp;
   logic signed [BITWIDTH-1:0] r_s1_data [LANES];

   // Stage 2: activation results presented on the output port.
   logic                       r_s2_valid;
   logic                       r_s2_last;
   logic signed [BITWIDTH-1:0] r_s2_data [LANES];

   logic                       w_adv1;
   logic                       w_adv2;
   logic                       w_accept;
   logic                       w_first;
   logic                       w_frame_last;
   logic [1:0]                 w_beat_mode;
   logic [4:0]                 w_beat_shift;
   logic signed [BITWIDTH-1:0] w_beat_clamp;
   logic signed [BITWIDTH-1:0] w_clamp_pos;
   logic signed [BITWIDTH-1:0] w_act [LANES];

   // Stage 2 moves when it is empty or being drained; stage 1 moves when stage 2 can take it.
   assign w_adv2   = !r_s2_valid | out_ready;
   assign w_adv1   = !r_s1_valid | w_adv2;
   assign in_ready = w_adv1 & !rst;
   assign w_accept = in_valid & in_ready;

   assign w_first      = (r_beat_cnt == '0);
   assign w_frame_last = (r_beat_cnt == LAST_CNT);

   // The first beat of a frame uses the live inputs; later beats reuse the latched copy.
   assign w_beat_mode  = w_first ? mode       : r_cfg_mode;
   assign w_beat_shift = w_first ? leak_shift : r_cfg_shift;
   assign w_beat_clamp = w_first ? clamp_max  : r_cfg_clamp;

   // Beat counter: advances on every accepted input beat and wraps at the frame end.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_beat_cnt <= '0;
      end else if (w_accept) begin
         r_beat_cnt <= w_frame_last ? '0 : r_beat_cnt + CNT_W'(1);
      end
   end

   // Frame config latch: captured only when a frame's first beat is accepted.
   always_ff @(posedge clk) begin
      if (w_accept && w_first) begin
         r_cfg_mode  <= mode;
         r_cfg_shift <= leak_shift;
         r_cfg_clamp <= clamp_max;
      end
   end

   // Stage 1 occupancy: refilled or emptied whenever the stage is allowed to advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
      end else if (w_adv1) begin
         r_s1_valid <= in_valid;
      end
   end

   // Stage 1 payload: loaded only on an input handshake.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_s1_data  <= in_data;
         r_s1_mode  <= w_beat_mode;
         r_s1_shift <= w_beat_shift;
         r_s1_clamp <= w_beat_clamp;
         r_s1_last  <= w_frame_last;
      end
   end

   // A negative clamp bound collapses the clamp window to exactly zero.
   assign w_clamp_pos = r_s1_clamp[BITWIDTH-1] ? '0 : r_s1_clamp;

   // Per-lane activation, all lanes sharing the beat's config.
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         w_act[i] = r_s1_data[i];
         case (r_s1_mode)
            MODE_RELU: begin
               if (r_s1_data[i][BITWIDTH-1]) begin
                  w_act[i] = '0;
               end
            end
            MODE_LEAKY: begin
               // Arithmetic shift floors toward -inf and saturates at -1 for large shifts.
               if (r_s1_data[i][BITWIDTH-1]) begin
                  w_act[i] = r_s1_data[i] >>> r_s1_shift;
               end
            end
            MODE_CLAMP: begin
               if (r_s1_data[i][BITWIDTH-1]) begin
                  w_act[i] = '0;
               end else if (r_s1_data[i] > w_clamp_pos) begin
                  w_act[i] = w_clamp_pos;
               end
            end
            default: begin
               w_act[i] = r_s1_data[i];
            end
         endcase
      end
   end

   // Stage 2: output register; contents only change when the held beat has been taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_last  <= 1'b0;
         for (int i = 0; i < LANES; i++) begin
            r_s2_data[i] <= '0;
         end
      end else if (w_adv2) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_last <= r_s1_last;
            r_s2_data <= w_act;
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign out_last  = r_s2_last;
   assign out_data  = r_s2_data;

`ifdef ACTIVATION_STREAM_STATS_EN
   logic            w_out_hs;
   logic [ZC_W-1:0] w_zeros;
   logic [ZC_W-1:0] r_zero_acc;
   logic [ZC_W-1:0] r_zero_count;
   logic            r_zero_valid;

   assign w_out_hs = r_s2_valid & out_ready;

   // Number of zero lanes in the beat currently on the output.
   always_comb begin
      w_zeros = '0;
      for (int i = 0; i < LANES; i++) begin
         if (r_s2_data[i] == '0) begin
            w_zeros = w_zeros + ZC_W'(1);
         end
      end
   end

   // Frame zero accumulator: publishes the total on the last beat's handshake, then clears.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_zero_acc   <= '0;
         r_zero_count <= '0;
         r_zero_valid <= 1'b0;
      end else begin
         r_zero_valid <= 1'b0;
         if (w_out_hs) begin
            if (r_s2_last) begin
               r_zero_count <= r_zero_acc + w_zeros;
               r_zero_valid <= 1'b1;
               r_zero_acc   <= '0;
            end else begin
               r_zero_acc <= r_zero_acc + w_zeros;
            end
         end
      end
   end

   assign zero_count       = r_zero_count;
   assign zero_count_valid = r_zero_valid;
`else
   assign zero_count       = '0;
   assign zero_count_valid = 1'b0;
`endif

endmodule

// File: tb/tb_activation_stream.sv
// tb/tb_activation_stream.sv - randomized and directed self-checking bench for activation_stream
module tb_activation_stream;

   localparam int BW = 32;
   localparam int LN = 4;
   localparam int FB = 3;
   localparam int ZW = $clog2(LN*FB+1);
`ifdef ACTIVATION_STREAM_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [1:0]           mode = 2'b00;
   logic [4:0]           leak_shift = 5'd0;
   logic signed [BW-1:0] clamp_max = '0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic signed [BW-1:0] in_data [LN];
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic signed [BW-1:0] out_data [LN];
   logic                 out_last;
   logic [ZW-1:0]        zero_count;
   logic                 zero_count_valid;

   always #5 clk = ~clk;

   activation_stream #(.BITWIDTH(BW), .LANES(LN), .FRAME_BEATS(FB)) dut (
      .clk(clk), .rst(rst), .mode(mode), .leak_shift(leak_shift), .clamp_max(clamp_max),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .zero_count(zero_count), .zero_count_valid(zero_count_valid)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic [LN-1:0][BW-1:0] d;
      logic                  last;
      int                    t;
   } item_t;

   item_t                 q[$];
   int                    cyc = 0;
   int                    fidx = 0;
   logic [1:0]            cfg_mode;
   int                    cfg_shift;
   logic signed [BW-1:0]  cfg_clamp;
   int                    zacc = 0;
   int                    zhold = 0;
   bit                    zpulse = 1'b0;
   logic [LN-1:0][BW-1:0] last_pop;
   bit                    popped = 1'b0;
   bit                    last_hs_in = 1'b0;

   function automatic logic [BW-1:0] ref_act(input logic signed [BW-1:0] x, input logic [1:0] m,
                                             input int s, input logic signed [BW-1:0] c);
      longint xv, cv, d, qq, cm, xp;
      xv = x;
      cv = c;
      qq = xv;
      case (m)
         2'd1: qq = (xv < 0) ? 0 : xv;
         2'd2: begin
            if (xv < 0) begin
               d  = longint'(1) << s;
               qq = xv / d;
               if (qq * d != xv) qq = qq - 1;
            end
         end
         2'd3: begin
            cm = (cv < 0) ? 0 : cv;
            xp = (xv < 0) ? 0 : xv;
            qq = (xp < cm) ? xp : cm;
         end
         default: qq = xv;
      endcase
      return 32'(qq);
   endfunction

   task automatic step(input bit v, input bit ordy, input bit r);
      bit    exp_rdy, exp_ov, hs_in, hs_out;
      item_t it;
      int    z;
      rst = r;
      in_valid = v;
      out_ready = ordy;
      #1;
      exp_rdy = !r && !(q.size() == 2 && !ordy);
      chk("in_ready", in_ready, exp_rdy);
      exp_ov = (q.size() > 0) && (cyc >= q[0].t + 1);
      hs_in  = v && exp_rdy;
      hs_out = exp_ov && ordy && !r;
      last_hs_in = hs_in;
      zpulse = 1'b0;
      if (hs_out) begin
         it = q.pop_front();
         last_pop = it.d;
         popped = 1'b1;
         z = 0;
         for (int i = 0; i < LN; i++) if (it.d[i] == '0) z++;
         if (it.last) begin
            zhold = zacc + z;
            zacc = 0;
            zpulse = 1'b1;
         end else begin
            zacc = zacc + z;
         end
      end
      if (hs_in) begin
         if (fidx == 0) begin
            cfg_mode  = mode;
            cfg_shift = int'(leak_shift);
            cfg_clamp = clamp_max;
         end
         for (int i = 0; i < LN; i++) it.d[i] = ref_act(in_data[i], cfg_mode, cfg_shift, cfg_clamp);
         it.last = (fidx == FB - 1);
         it.t = cyc + 1;
         q.push_back(it);
         fidx = (fidx + 1) % FB;
      end
      if (r) begin
         q.delete();
         fidx = 0;
         zacc = 0;
         zhold = 0;
         zpulse = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      exp_ov = (q.size() > 0) && (cyc >= q[0].t + 1);
      chk("out_valid", out_valid, exp_ov);
      if (exp_ov) begin
         for (int i = 0; i < LN; i++) chk("out_data", $unsigned(out_data[i]), q[0].d[i]);
         chk("out_last", out_last, q[0].last);
      end
      if (r) begin
         chk("rst_out_last", out_last, 1'b0);
         for (int i = 0; i < LN; i++) chk("rst_out_data", $unsigned(out_data[i]), 0);
      end
      chk("zero_count_valid", zero_count_valid, STATS ? zpulse : 1'b0);
      chk("zero_count", zero_count, STATS ? ZW'(zhold) : ZW'(0));
   endtask

   task automatic rand_data();
      int k;
      for (int i = 0; i < LN; i++) begin
         k = $urandom % 4;
         case (k)
            0: in_data[i] = '0;
            1: in_data[i] = int'($urandom_range(0, 40)) - 20;
            2: in_data[i] = $urandom;
            default: in_data[i] = $urandom | 32'h8000_0000;
         endcase
      end
   endtask

   task automatic directed(input string tag, input logic [1:0] m, input int s, input int c,
                           input int x0, input int x1, input int x2, input int x3,
                           input int e0, input int e1, input int e2, input int e3);
      step(0, 0, 1);
      mode = m;
      leak_shift = 5'(s);
      clamp_max = c;
      in_data[0] = x0; in_data[1] = x1; in_data[2] = x2; in_data[3] = x3;
      popped = 1'b0;
      step(1, 1, 0);
      for (int k = 0; k < 6 && !popped; k++) step(0, 1, 0);
      chk({tag, "_seen"}, popped, 1'b1);
      chk({tag, "_l0"}, last_pop[0], $unsigned(e0));
      chk({tag, "_l1"}, last_pop[1], $unsigned(e1));
      chk({tag, "_l2"}, last_pop[2], $unsigned(e2));
      chk({tag, "_l3"}, last_pop[3], $unsigned(e3));
   endtask

   initial begin
      int sent;
      bit saw_block;
      for (int i = 0; i < LN; i++) in_data[i] = '0;
      step(0, 0, 1);
      step(0, 1, 1);

      directed("relu",     2'd1, 0, 0,  -5, 0, 7, -1,   0, 0, 7, 0);
      directed("ident",    2'd0, 0, 0,  -5, 0, 7, -1,  -5, 0, 7, -1);
      directed("leaky2",   2'd2, 2, 0,  -8, -7, 9, -3, -2, -2, 9, -1);
      directed("leaky31",  2'd2, 31, 0, -3, 5, -2147483647 - 1, 0, -1, 5, -1, 0);
      directed("clamp6",   2'd3, 0, 6,  -4, 3, 6, 100,  0, 3, 6, 6);
      directed("clampneg", 2'd3, 0, -2, -4, 3, 6, 100,  0, 0, 0, 0);

      // Backpressure: five beats with a four-cycle output stall mid-stream.
      step(0, 0, 1);
      mode = 2'd1;
      sent = 0;
      saw_block = 1'b0;
      for (int k = 0; k < 16; k++) begin
         rand_data();
         step(sent < 5, !(k >= 2 && k < 6), 0);
         if (sent < 5 && !last_hs_in) saw_block = 1'b1;
         if (last_hs_in) sent++;
      end
      chk("bp_sent", sent, 5);
      chk("bp_blocked", saw_block, 1'b1);

      // Frames: ReLU captured at beat 0, identity requested from beat 1 onward.
      step(0, 0, 1);
      for (int k = 0; k < 6; k++) begin
         mode = (k == 0) ? 2'd1 : 2'd0;
         for (int i = 0; i < LN; i++) in_data[i] = -(k * 4 + i + 1);
         step(1, 1, 0);
      end
      for (int k = 0; k < 4; k++) step(0, 1, 0);

      // Reset mid-frame, then a fresh frame.
      for (int k = 0; k < 4; k++) begin
         rand_data();
         step(1, 1, 0);
      end
      step(0, 0, 1);
      for (int k = 0; k < 3; k++) begin
         rand_data();
         step(1, 1, 0);
      end
      for (int k = 0; k < 4; k++) step(0, 1, 0);

      // Randomized traffic with config churn, stalls and occasional reset.
      for (int k = 0; k < 2000; k++) begin
         rand_data();
         mode = 2'($urandom % 4);
         leak_shift = 5'($urandom % 32);
         clamp_max = int'($urandom_range(0, 80)) - 20;
         step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 150) == 0);
      end
      for (int k = 0; k < 8; k++) step(0, 1, 0);
      chk("drained", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/activation_stream.md
# activation_stream

Streaming, parametrised activation unit that applies a runtime-selectable activation function to a vector of `LANES` signed values per beat. It uses a two-stage registered pipeline with valid/ready handshakes on both sides. It sits between a layer's accumulator output and the next layer's input buffer. It tracks frame boundaries, marks the last beat of each frame, and optionally reports sparsity statistics per frame.

## Interface
- `BITWIDTH`, 32, signed element width.
- `LANES`, 10, elements per beat.
- `FRAME_BEATS`, 1, beats per frame; must be ≥1.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `mode`  in  2  activation select: 00 identity, 01 ReLU, 10 leaky ReLU, 11 clamped ReLU.
- `leak_shift`  in  5  arithmetic right-shift amount for leaky mode.
- `clamp_max`  in  BITWIDTH  signed upper bound for clamped mode.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  unit can accept a beat.
- `in_data`  in  BITWIDTH × [LANES-1:0] unpacked signed input vector.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream accepts the beat.
- `out_data`  out  BITWIDTH × [LANES-1:0] unpacked signed result vector.
- `out_last`  out  1  marks the final beat of a frame.
- `zero_count`  out  $clog2(LANES*FRAME_BEATS+1)  number of zero output elements in the completed frame.
- `zero_count_valid`  out  1  one-cycle pulse that qualifies `zero_count`.

## Operation
- Handshake:
  - A beat transfers on a port when valid and ready are both high in the same cycle.
  - `out_valid` is never withdrawn, and `out_data`/`out_last` are held stable, until the beat is accepted.
- Pipeline:
  - S1 registers `in_data`, the frame config and the last flag.
  - S2 registers the activation result.
  - Advance rules:
    - `adv2 = !s2_valid | out_ready`.
    - `adv1 = !s1_valid | adv2`.
    - `in_ready = adv1 & !rst`, combinational.
- Frame config:
  - `mode`, `leak_shift` and `clamp_max` are captured when the first beat of a frame is accepted (beat counter = 0).
  - The captured values apply to every beat of that frame.
  - Changes to these inputs mid-frame are ignored until the next frame starts.
- Beat counter:
  - Increments on each accepted input beat.
  - Wraps to 0 after reaching `FRAME_BEATS-1`.
  - The beat accepted at count `FRAME_BEATS-1` carries last=1 through the pipeline and appears on `out_last`.
  - With `FRAME_BEATS`=1, every beat is last.
- Per-lane function (x = signed input; output width is `BITWIDTH`, no growth):
  - identity: y = x.
  - ReLU: y = x if the sign bit is 0, else y = 0.
  - leaky: y = x if x ≥ 0, else y = x >>> leak_shift.
    - Arithmetic shift rounds toward −∞.
    - A shift ≥ `BITWIDTH` yields −1 for any negative x.
  - clamped: y = min(max(x,0), max(clamp_max,0)).
    - A negative `clamp_max` forces all outputs to 0.
- All lanes are computed in parallel and share one config.

## Timing
- Latency: 2 cycles from input acceptance to `out_valid`, with no backpressure.
- Throughput: 1 beat/cycle sustained while `out_ready`=1.
- Backpressure:
  - With `out_ready`=0 and both stages full, `in_ready`=0 in the same cycle.
  - Up to 2 beats are buffered.
  - No beat is lost or duplicated.
- Reset values: `out_valid`=0, `out_data`=0 (all lanes), `out_last`=0, `zero_count`=0, `zero_count_valid`=0, `in_ready`=0 while `rst`=1. The beat counter and both stage valids are also 0.
- Reset mid-frame discards all in-flight beats and the partial frame. The first beat after reset starts a new frame and captures config.
- Simultaneous accept on input and output in one cycle is legal; occupancy is unchanged.
- Acceptance at count `FRAME_BEATS-1` in the same cycle as a config change: the old config applies to that beat, and the new config is captured by the next accepted beat.

## Configuration
- Macro: `ACTIVATION_STREAM_STATS_EN`.
- Defined:
  - A counter accumulates the number of zero-valued output elements, counted on each output handshake.
  - On the handshake of an `out_last` beat, the frame total (including that beat) is registered to `zero_count`.
  - `zero_count_valid` pulses high for exactly 1 cycle on the next cycle.
  - The accumulator then clears. `zero_count` holds its value until the next frame completes.
  - Reset clears the accumulator and both outputs.
- Not defined: `zero_count` and `zero_count_valid` are tied to 0, and no counter logic is instantiated.

## Test plan
- ReLU, `LANES`=10, input {−5,0,7,−1,…}:
  - Output {0,0,7,0,…} two cycles after acceptance.
  - `out_last`=1 when `FRAME_BEATS`=1.
- Leaky, `leak_shift`=2:
  - −8 → −2, −7 → −2, 9 → 9.
  - With `leak_shift`=31: −3 → −1.
- Clamped, `clamp_max`=6: {−4,3,6,100} → {0,3,6,6}. With `clamp_max`=−2, all outputs are 0.
- Backpressure:
  - Stream 5 beats and hold `out_ready`=0 for 4 cycles mid-stream.
  - `in_ready` drops after 2 beats are buffered.
  - The output sequence is identical and in order, with stable data while stalled.
- Frames and reset:
  - `FRAME_BEATS`=3; switch `mode` from ReLU to identity at beat 1.
    - Beats 0–2 use ReLU, beat 3 uses identity.
    - `out_last` is set on beats 2 and 5 only.
  - Assert `rst` after beat 4.
    - `out_valid` is 0 next cycle.
    - The next accepted beat starts a new frame, so `out_last` is set on its third beat.
- Stats, with `ACTIVATION_STREAM_STATS_EN` defined:
  - `FRAME_BEATS`=2, `LANES`=4, inputs {−1,2,0,3},{−2,−3,5,1}, ReLU.
  - `zero_count`=4 with a 1-cycle `zero_count_valid` pulse after the last handshake.
  - Without the macro, both outputs stay 0.
